// File: rtl/algo_2rw_a54_pkg.sv
// rtl/algo_2rw_a54_pkg.sv - shared constants and pipeline-entry type for the 2RW read pipe
package algo_2rw_a54_pkg;
    localparam int NUMRWPT = 2;
    localparam int NUMPBNK = NUMRWPT * NUMRWPT;
    localparam int BITPBNK = 2;
    localparam int BITSROW = 11;
    localparam int BITPADR = BITPBNK + BITSROW;

    typedef struct packed {
        logic               vld;
        logic [BITPBNK-1:0] bank;
        logic [BITSROW-1:0] row;
    } rdpipe_ent_t;
endpackage

// File: rtl/algo_2rw_a54_rdpipe_port.sv
// rtl/algo_2rw_a54_rdpipe_port.sv - one port's read delay pipeline, bank mux and parity check
module algo_2rw_a54_rdpipe_port
    import algo_2rw_a54_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int ENAPAR     = 0,
    parameter int SRAM_DELAY = 1,
    parameter int FLOPOUT    = 0,
    localparam int PHYWDTH   = WIDTH + ENAPAR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc,
    input  logic [BITPBNK-1:0]         bank,
    input  logic [BITSROW-1:0]         row,
    input  logic [NUMPBNK*PHYWDTH-1:0] t1_doutB,
    output logic                       vld,
    output logic [WIDTH-1:0]           dout,
    output logic                       serr,
    output logic [BITPADR-1:0]         padr
);
    rdpipe_ent_t        pipe_q [SRAM_DELAY];
    rdpipe_ent_t        pipe_d [SRAM_DELAY];
    rdpipe_ent_t        tail;
    logic [PHYWDTH-1:0] word;
    logic               perr;
    logic               out_vld_q, out_vld_d;
    logic               out_serr_q, out_serr_d;
    logic [WIDTH-1:0]   out_dout_q, out_dout_d;
    logic [BITPADR-1:0] out_padr_q, out_padr_d;

    // Accepted issues enter at stage 0 and advance one stage per cycle
    always_comb begin
        pipe_d[0] = '{vld: acc, bank: bank, row: row};
        for (int i = 1; i < SRAM_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Delay pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SRAM_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Tail stage selects the bank word and checks its even parity
    always_comb begin
        tail = pipe_q[SRAM_DELAY-1];
        word = t1_doutB[int'(tail.bank)*PHYWDTH +: PHYWDTH];
        perr = (ENAPAR != 0) && (^word);
    end

    // Next output values; data/address hold their last value between returns
    always_comb begin
        out_vld_d  = tail.vld;
        out_serr_d = tail.vld & perr;
        out_dout_d = out_dout_q;
        out_padr_d = out_padr_q;
        if (tail.vld) begin
            out_dout_d = word[WIDTH-1:0];
            out_padr_d = {tail.bank, tail.row};
        end
    end

    // Output/hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_serr_q <= 1'b0;
            out_dout_q <= '0;
            out_padr_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_serr_q <= out_serr_d;
            out_dout_q <= out_dout_d;
            out_padr_q <= out_padr_d;
        end
    end

    // Registered or combinational output stage
    always_comb begin
        if (FLOPOUT != 0) begin
            vld  = out_vld_q;
            serr = out_serr_q;
            dout = out_dout_q;
            padr = out_padr_q;
        end else begin
            vld  = out_vld_d;
            serr = out_serr_d;
            dout = out_dout_d;
            padr = out_padr_d;
        end
    end
endmodule

// File: rtl/algo_2rw_a54_rdpipe.sv
// rtl/algo_2rw_a54_rdpipe.sv - 2RW read-return pipeline top with bank-conflict flag
module algo_2rw_a54_rdpipe
    import algo_2rw_a54_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int ENAPAR     = 0,
    parameter int SRAM_DELAY = 1,
    parameter int FLOPOUT    = 0,
    localparam int MEMWDTH   = WIDTH + ENAPAR,
    localparam int PHYWDTH   = MEMWDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMRWPT-1:0]         rd_issue,
    input  logic [NUMRWPT*BITPBNK-1:0] rd_bank,
    input  logic [NUMRWPT*BITSROW-1:0] rd_row,
    input  logic [NUMPBNK*PHYWDTH-1:0] t1_doutB,
    output logic [NUMRWPT-1:0]         rw_vld,
    output logic [NUMRWPT*WIDTH-1:0]   rw_dout,
    output logic [NUMRWPT-1:0]         rw_serr,
    output logic [NUMRWPT-1:0]         rw_derr,
    output logic [NUMRWPT*BITPADR-1:0] rw_padr,
    output logic                       bank_conflict
);
    logic [NUMRWPT-1:0] acc;
    logic               bank_conflict_q, bank_conflict_d;

    assign acc           = rd_issue & {NUMRWPT{ready}};
    assign rw_derr       = '0;
    assign bank_conflict = bank_conflict_q;

    // Sticky flag: two ports accepted reads to the same bank in one cycle
    always_comb begin
        bank_conflict_d = bank_conflict_q;
        for (int a = 0; a < NUMRWPT; a++) begin
            for (int b = a + 1; b < NUMRWPT; b++) begin
                if (acc[a] && acc[b] &&
                    (rd_bank[a*BITPBNK +: BITPBNK] == rd_bank[b*BITPBNK +: BITPBNK])) begin
                    bank_conflict_d = 1'b1;
                end
            end
        end
    end

    // Conflict flag register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_conflict_q <= 1'b0;
        end else begin
            bank_conflict_q <= bank_conflict_d;
        end
    end

    for (genvar p = 0; p < NUMRWPT; p++) begin : g_port
        algo_2rw_a54_rdpipe_port #(
            .WIDTH      (WIDTH),
            .ENAPAR     (ENAPAR),
            .SRAM_DELAY (SRAM_DELAY),
            .FLOPOUT    (FLOPOUT)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .acc      (acc[p]),
            .bank     (rd_bank[p*BITPBNK +: BITPBNK]),
            .row      (rd_row[p*BITSROW +: BITSROW]),
            .t1_doutB (t1_doutB),
            .vld      (rw_vld[p]),
            .dout     (rw_dout[p*WIDTH +: WIDTH]),
            .serr     (rw_serr[p]),
            .padr     (rw_padr[p*BITPADR +: BITPADR])
        );
    end
endmodule

// File: doc/algo_2rw_a54_rdpipe.md
ALGO_2RW_A54_RDPIPE -- requirements
Module: algo_2rw_a54_rdpipe

Interface
REQ-001 Parameter WIDTH, 64, logical data width per RW port.
REQ-002 Parameter ENAPAR, 0, 1 stores one even-parity bit per word in physical MSB.
REQ-003 Parameter NUMRWPT, 2, RW port count; NUMPBNK, 4 (NUMRWPT*NUMRWPT); BITPBNK, 2.
REQ-004 Parameter BITSROW, 11, physical row address width.
REQ-005 Parameter SRAM_DELAY, 1, t1 read latency in cycles (legal 1..4); FLOPOUT, 0, adds one output register stage (0/1).
REQ-006 Derived: MEMWDTH = WIDTH+ENAPAR; PHYWDTH = MEMWDTH; BITPADR = BITPBNK+BITSROW.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 ready  input  1  core initialised; issues ignored while low.
REQ-010 rd_issue  input  NUMRWPT  per-port read issued to t1 this cycle.
REQ-011 rd_bank  input  NUMRWPT*BITPBNK  physical bank of each issued read.
REQ-012 rd_row  input  NUMRWPT*BITSROW  physical row of each issued read.
REQ-013 t1_doutB  input  NUMPBNK*PHYWDTH  bank read data, valid SRAM_DELAY cycles after issue.
REQ-014 rw_vld  output  NUMRWPT  per-port read data valid.
REQ-015 rw_dout  output  NUMRWPT*WIDTH  per-port read data.
REQ-016 rw_serr  output  NUMRWPT  parity error on returned word.
REQ-017 rw_derr  output  NUMRWPT  double error; tied 0 in this block.
REQ-018 rw_padr  output  NUMRWPT*BITPADR  {bank,row} of returned word.
REQ-019 bank_conflict  output  1  sticky: both ports issued to same bank in one cycle.

Function
REQ-020 Port p issue accepted iff rd_issue[p] & ready; accepted {vld,bank,row} enter a SRAM_DELAY-deep per-port shift pipeline.
REQ-021 At pipeline tail, data = t1_doutB slice selected by tail bank; rw_dout[p] = low WIDTH bits.
REQ-022 Total latency issue -> rw_vld = SRAM_DELAY+FLOPOUT cycles, fixed, one result per accepted issue, in order.
REQ-023 ENAPAR=1: rw_serr[p] = XOR of all MEMWDTH bits of selected word (nonzero = error); ENAPAR=0: rw_serr=0.
REQ-024 rw_dout, rw_serr, rw_padr hold last value when rw_vld low; rw_serr asserted only with rw_vld.
REQ-025 Back-to-back issues every cycle on both ports sustain full throughput, no bubbles.
REQ-026 Same-bank issue on both ports in one cycle: both still return (same bank data) and bank_conflict sets, cleared only by rst.
REQ-027 ready falling with reads in flight: in-flight reads still complete; only new issues blocked.
REQ-028 FLOPOUT=1 registers rw_vld, rw_dout, rw_serr, rw_padr together; FLOPOUT=0 drives them combinationally from tail stage.

Reset
REQ-029 rst asserted: all pipeline valid bits, rw_vld, rw_serr, bank_conflict clear to 0 immediately (async); data/address registers clear to 0.
REQ-030 rst mid-operation drops all in-flight reads; no rw_vld for issues accepted before rst.
REQ-031 First issue accepted in the cycle after rst deasserts is returned normally.

Structure
REQ-032 Shared package algo_2rw_a54_pkg holds NUMRWPT, NUMPBNK, BITPBNK, BITPADR and the per-port pipeline-entry struct {vld,bank,row}.
REQ-033 One sub-module algo_2rw_a54_rdpipe_port (one port's delay pipeline, bank mux, parity check), instantiated NUMRWPT times.

Verification
REQ-034 SRAM_DELAY=2, FLOPOUT=0: port0 issue bank 1 row 0x005, bank1 returns 0x0_DEAD_BEEF at +2 -> rw_vld[0] at +2, rw_dout=0xDEADBEEF, rw_padr={1,0x005}.
REQ-035 ENAPAR=1: bank 3 returns word with odd total parity -> rw_serr of that port =1 with rw_vld; even parity -> 0.
REQ-036 Both ports issue bank 2 row 0x10 same cycle -> both rw_vld, identical rw_dout, bank_conflict=1 and stays 1 until rst.
REQ-037 Continuous issues 8 cycles, both ports, distinct banks, FLOPOUT=1 -> 8 consecutive rw_vld per port, latency SRAM_DELAY+1, in order.
REQ-038 rst pulsed one cycle after issue, SRAM_DELAY=3 -> no rw_vld ever for that issue; outputs 0 during rst.
REQ-039 ready=0 with rd_issue=1 -> no rw_vld; ready drop with 2 reads in flight -> both still return.
